// File: rtl/tail_light_monitor_if.sv
// Tail-light monitor bus: observed LED bus, counter clear,
// and the monitor's registered status outputs.
interface tail_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       leds;
    logic             clear;
    logic             active_left;
    logic             active_right;
    logic [1:0]       step;
    logic             sweep_done_left;
    logic             sweep_done_right;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] left_count;
    logic [CNT_W-1:0] right_count;
    logic [CNT_W-1:0] error_count;

    modport master (
        output leds, clear,
        input  active_left, active_right, step,
        input  sweep_done_left, sweep_done_right,
        input  error, err_code,
        input  left_count, right_count, error_count
    );

    modport slave (
        input  leds, clear,
        output active_left, active_right, step,
        output sweep_done_left, sweep_done_right,
        output error, err_code,
        output left_count, right_count, error_count
    );
endinterface

// File: rtl/tail_light_monitor.sv
// Tail-light sweep checker: tracks left/right LED sweeps,
// pulses on completion, classifies and counts errors.
module tail_light_monitor #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input logic                clk,
    input logic                reset_n,
    tail_light_monitor_if.slave bus
);
    localparam int HW = $clog2(STEP_CYCLES + 1);
    localparam logic [HW-1:0] HMAX = HW'(STEP_CYCLES);

    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, L4, R1, R2, R3, R4, ERR
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             err_d, done_l_d, done_r_d;
    logic [1:0]       code_q, code_d;
    logic             act_l_q, act_r_q, err_q;
    logic             done_l_q, done_r_q;
    logic [1:0]       step_q;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    function automatic logic [7:0] cur_pat(state_t s);
        case (s)
            L1:      return 8'h10;
            L2:      return 8'h30;
            L3:      return 8'h70;
            L4:      return 8'hF0;
            R1:      return 8'h08;
            R2:      return 8'h0C;
            R3:      return 8'h0E;
            R4:      return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic state_t adv(state_t s);
        case (s)
            L1:      return L2;
            L2:      return L3;
            L3:      return L4;
            R1:      return R2;
            R2:      return R3;
            R3:      return R4;
            default: return IDLE;
        endcase
    endfunction

    // Entry state chosen from a sample after IDLE or an error.
    function automatic state_t resync(logic [7:0] v);
        case (v)
            8'h00:   return IDLE;
            8'h10:   return L1;
            8'h08:   return R1;
            default: return ERR;
        endcase
    endfunction

    function automatic logic is_left(state_t s);
        return (s == L1) || (s == L2) || (s == L3) || (s == L4);
    endfunction

    function automatic logic is_right(state_t s);
        return (s == R1) || (s == R2) || (s == R3) || (s == R4);
    endfunction

    function automatic logic [1:0] step_of(state_t s);
        case (s)
            L2, R2:  return 2'd1;
            L3, R3:  return 2'd2;
            L4, R4:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Next state, hold count, error classification and counters.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        err_d    = 1'b0;
        code_d   = code_q;
        done_l_d = 1'b0;
        done_r_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = resync(bus.leds);
                if (state_d == ERR) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end
            end
            ERR: begin
                if (bus.leds == 8'h00) state_d = IDLE;
            end
            default: begin
                if (bus.leds == cur_pat(state_q)) begin
                    if (hold_q < HMAX) begin
                        hold_d = hold_q + 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end
                end else if (bus.leds == cur_pat(adv(state_q))) begin
                    if (hold_q == HMAX) begin
                        state_d  = adv(state_q);
                        done_l_d = (state_q == L4);
                        done_r_d = (state_q == R4);
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                end else begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end
                if (err_d) state_d = resync(bus.leds);
            end
        endcase
        if (is_left(state_d) || is_right(state_d)) begin
            if (state_d != state_q || err_d) hold_d = HW'(1);
        end else begin
            hold_d = '0;
        end

        lcnt_d = lcnt_q;
        rcnt_d = rcnt_q;
        ecnt_d = ecnt_q;
        if (done_l_d && lcnt_q != '1) lcnt_d = lcnt_q + 1'b1;
        if (done_r_d && rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
        if (err_d && ecnt_q != '1)    ecnt_d = ecnt_q + 1'b1;
        if (bus.clear) begin
            lcnt_d = '0;
            rcnt_d = '0;
            ecnt_d = '0;
        end
    end

    // State, hold and registered output decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            code_q   <= 2'd0;
            err_q    <= 1'b0;
            done_l_q <= 1'b0;
            done_r_q <= 1'b0;
            act_l_q  <= 1'b0;
            act_r_q  <= 1'b0;
            step_q   <= 2'd0;
            lcnt_q   <= '0;
            rcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            code_q   <= code_d;
            err_q    <= err_d;
            done_l_q <= done_l_d;
            done_r_q <= done_r_d;
            act_l_q  <= is_left(state_d);
            act_r_q  <= is_right(state_d);
            step_q   <= step_of(state_d);
            lcnt_q   <= lcnt_d;
            rcnt_q   <= rcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign bus.active_left      = act_l_q;
    assign bus.active_right     = act_r_q;
    assign bus.step             = step_q;
    assign bus.sweep_done_left  = done_l_q;
    assign bus.sweep_done_right = done_r_q;
    assign bus.error            = err_q;
    assign bus.err_code         = code_q;
    assign bus.left_count       = lcnt_q;
    assign bus.right_count      = rcnt_q;
    assign bus.error_count      = ecnt_q;
endmodule

// File: tb/tb_tail_light_monitor.sv
// Bench for tail_light_monitor: two instances (S=1/W=2, S=2/W=8)
// share one stimulus stream; a reference model feeds scoreboards.
module tb_tail_light_monitor;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tail_light_monitor_if #(.CNT_W(2)) bus1 ();
    tail_light_monitor_if #(.CNT_W(8)) bus2 ();

    tail_light_monitor #(.STEP_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    tail_light_monitor #(.STEP_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    typedef struct packed {
        logic       al;
        logic       ar;
        logic [1:0] step;
        logic       dl;
        logic       dr;
        logic       er;
        logic [1:0] code;
        logic [7:0] lc;
        logic [7:0] rc;
        logic [7:0] ec;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: mode 0 idle, 1 tracking, 2 error-wait.
    int S[2]    = '{1, 2};
    int MAXC[2] = '{3, 255};
    int mode[2], dir[2], idx[2], hold[2], code[2];
    int lc[2], rc[2], ec[2];
    logic [7:0] SEQ[2][4] = '{'{8'h10, 8'h30, 8'h70, 8'hF0},
                              '{8'h08, 8'h0C, 8'h0E, 8'h0F}};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; dir[k] = 0; idx[k] = 0; hold[k] = 0;
            code[k] = 0; lc[k] = 0; rc[k] = 0; ec[k] = 0;
        end
    endtask

    task automatic enter(int k, logic [7:0] v);
        if (v == 8'h00) mode[k] = 0;
        else if (v == 8'h10) begin
            mode[k] = 1; dir[k] = 0; idx[k] = 0; hold[k] = 1;
        end else if (v == 8'h08) begin
            mode[k] = 1; dir[k] = 1; idx[k] = 0; hold[k] = 1;
        end else mode[k] = 2;
    endtask

    task automatic model(int k, logic [7:0] v, logic clr,
                         output exp_t e);
        int err, dl, dr;
        logic [7:0] cur, nxt;
        err = 0; dl = 0; dr = 0;
        if (mode[k] == 0) begin
            enter(k, v);
            if (mode[k] == 2) begin err = 1; code[k] = 1; end
        end else if (mode[k] == 2) begin
            if (v == 8'h00) mode[k] = 0;
        end else begin
            cur = SEQ[dir[k]][idx[k]];
            nxt = (idx[k] == 3) ? 8'h00 : SEQ[dir[k]][idx[k] + 1];
            if (v == cur) begin
                if (hold[k] < S[k]) hold[k]++;
                else begin err = 1; code[k] = 3; end
            end else if (v == nxt) begin
                if (hold[k] == S[k]) begin
                    if (idx[k] == 3) begin
                        mode[k] = 0;
                        if (dir[k] == 0) dl = 1; else dr = 1;
                    end else begin
                        idx[k]++; hold[k] = 1;
                    end
                end else begin err = 1; code[k] = 2; end
            end else begin err = 1; code[k] = 1; end
            if (err != 0) enter(k, v);
        end
        if (clr) begin lc[k] = 0; rc[k] = 0; ec[k] = 0; end
        else begin
            if (dl != 0 && lc[k] < MAXC[k]) lc[k]++;
            if (dr != 0 && rc[k] < MAXC[k]) rc[k]++;
            if (err != 0 && ec[k] < MAXC[k]) ec[k]++;
        end
        e.al   = (mode[k] == 1) && (dir[k] == 0);
        e.ar   = (mode[k] == 1) && (dir[k] == 1);
        e.step = (mode[k] == 1) ? 2'(idx[k]) : 2'd0;
        e.dl   = 1'(dl);
        e.dr   = 1'(dr);
        e.er   = 1'(err);
        e.code = 2'(code[k]);
        e.lc   = 8'(lc[k]);
        e.rc   = 8'(rc[k]);
        e.ec   = 8'(ec[k]);
    endtask

    task automatic apply(logic [7:0] v, logic clr);
        exp_t e;
        bus1.leds = v; bus1.clear = clr;
        bus2.leds = v; bus2.clear = clr;
        model(0, v, clr, e); q1.push_back(e);
        model(1, v, clr, e); q2.push_back(e);
    endtask

    task automatic drive(logic [7:0] v, logic clr = 1'b0);
        @(negedge clk);
        apply(v, clr);
    endtask

    task automatic sweep(int d, int h, int corrupt, logic clr_end);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < h; j++)
                if (corrupt != 0 && $urandom_range(0, 11) == 0)
                    drive(8'($urandom));
                else
                    drive(SEQ[d][i]);
        drive(8'h00, clr_end);
    endtask

    function automatic exp_t act1();
        return '{bus1.active_left, bus1.active_right, bus1.step,
                 bus1.sweep_done_left, bus1.sweep_done_right,
                 bus1.error, bus1.err_code, 8'(bus1.left_count),
                 8'(bus1.right_count), 8'(bus1.error_count)};
    endfunction

    function automatic exp_t act2();
        return '{bus2.active_left, bus2.active_right, bus2.step,
                 bus2.sweep_done_left, bus2.sweep_done_right,
                 bus2.error, bus2.err_code, bus2.left_count,
                 bus2.right_count, bus2.error_count};
    endfunction

    task automatic check(string name, exp_t a, exp_t e);
        total_cnt++;
        if (a === e) pass_cnt++;
        else
            $display("FAIL %s t=%0t got al=%b ar=%b st=%0d dl=%b dr=%b er=%b cd=%0d lc=%0d rc=%0d ec=%0d expected al=%b ar=%b st=%0d dl=%b dr=%b er=%b cd=%0d lc=%0d rc=%0d ec=%0d",
                     name, $time, a.al, a.ar, a.step, a.dl, a.dr, a.er,
                     a.code, a.lc, a.rc, a.ec, e.al, e.ar, e.step, e.dl,
                     e.dr, e.er, e.code, e.lc, e.rc, e.ec);
    endtask

    // Monitor: outputs reflect each sample right after the next edge.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (q1.size() > 0) check("dut1_s1", act1(), q1.pop_front());
            if (q2.size() > 0) check("dut2_s2", act2(), q2.pop_front());
        end
    end

    initial begin
        bus1.leds = 8'h00; bus1.clear = 1'b0;
        bus2.leds = 8'h00; bus2.clear = 1'b0;
        model_reset();
        #12;
        check("reset1", act1(), '0);
        check("reset2", act2(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(8'h00, 1'b0);
        drive(8'h00);

        sweep(0, 1, 0, 1'b0);
        sweep(1, 2, 0, 1'b0);
        drive(8'h08); drive(8'h08); drive(8'h08);
        drive(8'h00);
        drive(8'h10); drive(8'h30); drive(8'h00);
        drive(8'h10); drive(8'h30); drive(8'h00);
        drive(8'h55); drive(8'h10); drive(8'h00);
        drive(8'h00);
        for (int i = 0; i < 5; i++) sweep(0, 1, 0, 1'b0);
        sweep(0, 1, 0, 1'b1);
        sweep(0, 2, 0, 1'b0);
        sweep(1, 1, 0, 1'b0);
        sweep(1, 2, 0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3:
                    sweep(int'($urandom_range(0, 1)),
                          int'($urandom_range(1, 3)), 0, 1'b0);
                4, 5:
                    sweep(int'($urandom_range(0, 1)),
                          int'($urandom_range(1, 3)), 1, 1'b0);
                6: drive(8'($urandom));
                7: repeat ($urandom_range(1, 3)) drive(8'h00);
                8: drive(8'h00, 1'b1);
                default:
                    sweep(int'($urandom_range(0, 1)),
                          int'($urandom_range(1, 2)), 0, 1'b1);
            endcase
        end

        drive(8'h00); drive(8'h00);
        drive(8'h08); drive(8'h0C); drive(8'h0E);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst1", act1(), '0);
        check("async_rst2", act2(), '0);
        model_reset();
        bus1.leds = 8'h00; bus2.leds = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        apply(8'h0E, 1'b0);
        drive(8'h00);
        drive(8'h00);
        repeat (3) @(posedge clk);
        #2;
        total_cnt++;
        if (q1.size() == 0 && q2.size() == 0) pass_cnt++;
        else $display("FAIL drain q1=%0d q2=%0d required 0", q1.size(), q2.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/tail_light_monitor.md
# tail_light_monitor

Receive-side checker for the 8-bit tail-light LED bus. It samples the bus every clock, tracks the left and right sweep sequences step by step, and reports the active direction and current step. It pulses on every completed sweep, counts completed sweeps per direction, and flags and classifies any illegal pattern or timing. It sits on the same clock as the light controller and observes its LED outputs in board self-test and in simulation.

## Interface
- STEP_CYCLES, 1: cycles each sweep pattern must be held; legal range ≥1.
- CNT_W, 8: width of the sweep and error counters.

- clk  in  1  rising-edge clock, same clock as the LED driver.
- reset_n  in  1  reset, asynchronous, active-low.
- leds  in  8  observed LED bus.
- clear  in  1  synchronous clear of all three counters.
- active_left  out  1  high while a left sweep is being tracked.
- active_right  out  1  high while a right sweep is being tracked.
- step  out  2  current step index, 0–3 (0 when idle or in error).
- sweep_done_left  out  1  one-cycle pulse on a completed left sweep.
- sweep_done_right  out  1  one-cycle pulse on a completed right sweep.
- error  out  1  one-cycle pulse on an illegal sample.
- err_code  out  2  code of the last error, held until the next error. 1 = illegal pattern, 2 = early change, 3 = stuck.
- left_count  out  CNT_W  completed left sweeps, saturating.
- right_count  out  CNT_W  completed right sweeps, saturating.
- error_count  out  CNT_W  errors, saturating.

## Operation
- Left sequence: 0x10, 0x30, 0x70, 0xF0, then 0x00.
- Right sequence: 0x08, 0x0C, 0x0E, 0x0F, then 0x00.
- States: IDLE, L1–L4, R1–R4, ERR.
- Hold counter `hold` counts consecutive cycles the current pattern has been sampled. Width is clog2(STEP_CYCLES+1). It is set to 1 on entry to any L/R state.
- IDLE:
  - 0x00 → stay.
  - 0x10 → L1.
  - 0x08 → R1.
  - Anything else → error, code 1, go to ERR.
- Ln/Rn, classification in priority order:
  - Sample equals the current pattern and hold < STEP_CYCLES → stay, hold+1.
  - Sample equals the current pattern and hold == STEP_CYCLES → error, code 3 (stuck).
  - Sample equals the next expected pattern and hold == STEP_CYCLES → advance.
  - Sample equals the next expected pattern and hold < STEP_CYCLES → error, code 2 (early change).
  - Any other value, including 0x00 before step 4 completes → error, code 1.
- Advance from L4/R4 means sampling 0x00. This pulses sweep_done_left/right, increments the matching count, and goes to IDLE.
- State after an error (resync) is chosen from the same sample:
  - 0x00 → IDLE.
  - 0x10 → L1.
  - 0x08 → R1.
  - Anything else → ERR.
- ERR:
  - Non-zero samples hold the state with no further error pulses.
  - 0x00 → IDLE.
  - ERR does not resync directly into L1/R1; it must see 0x00 first.
- Counters:
  - Saturate at all-ones.
  - clear has priority over a same-cycle increment; the result is 0.
  - error_count increments once per error pulse.
- Output decode:
  - active_left is high in L1–L4; active_right is high in R1–R4.
  - step = n-1 in Ln/Rn.
  - All outputs are registered.
- Reset values:
  - State IDLE, hold 0.
  - All pulses 0, active flags 0, step 0, err_code 0, all counts 0.
- Reset mid-sweep aborts tracking with no error and no done pulse. The first sample after release is treated as in IDLE.

## Timing
- A sample presented before rising edge k is reflected on the outputs right after edge k (1-cycle latency). There is no combinational path from leds to any output.
- A sweep with STEP_CYCLES=S occupies 4·S cycles of non-zero patterns. The done pulse is asserted one cycle after the first 0x00 sample.
- Back-to-back sweeps are legal with a single 0x00 between them.
- A direction switch (left sweep, one 0x00, right sweep) is legal.
- Pulses are exactly one cycle wide, including consecutive errors in ERR→IDLE→error chains.

## Test plan
- S=1, leds 0x00,0x10,0x30,0x70,0xF0,0x00:
  - active_left high for 4 cycles with step 0,1,2,3.
  - sweep_done_left pulses once; left_count=1; error never.
- S=2, right sequence with each value held 2 cycles, then 0x00:
  - right_count=1.
  - Repeat with 0x08 held 3 cycles → error, err_code=3, error_count=1.
- S=2, 0x10 held for 1 cycle then 0x30 → error, err_code=2. Then 0x00 → IDLE, with no done pulse.
- S=1, left sweep aborted by 0x00 after 0x30 → err_code=1, state IDLE. Then 0x55 from IDLE → err_code=1 and state ERR; a subsequent 0x10 gives no pulse; then 0x00 → IDLE.
- CNT_W=2, five complete left sweeps → left_count saturates at 3. Assert clear on the same cycle as a done pulse → left_count=0.
- Assert reset_n low during R3 → all outputs reset within the same cycle, asynchronously. After release, a 0x0E sample → error code 1.
